hs32_mem_arbiter: RTL and testbench

- Responder end of the fetch-unit memory handshake (addr/reqm/ackm/dtr) and of the execute-stage load/store handshake.
- Arbitrates between the two requesters and drives a single 32-bit word-wide external memory bus with a ready-based wait.
- Sits between the CPU core (fetch and execute stages) and the SoC memory / SRAM controller.
- One transaction is in flight at a time, so responses are never reordered.

---
 rtl/hs32_pkg.sv | 17 +
 rtl/hs32_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_hs32_mem_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hs32_pkg.sv
// Shared encodings for the hs32 memory arbiter: FSM states, transaction owner, default widths.
package hs32_pkg;

  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_EXEC  = 1'b1
  } owner_e;

endpackage

// File: rtl/hs32_mem_arbiter.sv
// Fetch/execute arbiter onto one word-wide memory bus; one transaction in flight, ack 3 cycles after request at zero wait.
// Memory stalls by holding m_rdy low (m_stb held); requesters stall by holding reqm until their one-cycle ack.
module hs32_mem_arbiter
  import hs32_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit FAIR   = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_reqm,
  output logic [31:0]       f_dtr,
  output logic              f_ackm,
  input  logic              flush,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [31:0]       x_dtw,
  input  logic              x_rw,
  input  logic              x_reqm,
  output logic [31:0]       x_dtr,
  output logic              x_ackm,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_dout,
  output logic              m_we,
  output logic              m_stb,
  input  logic [31:0]       m_din,
  input  logic              m_rdy
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_grant_q, last_grant_d;
  logic                flush_pend_q, flush_pend_d;
  logic                m_stb_q, m_stb_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [31:0]         m_dout_q, m_dout_d;
  logic                f_ack_q, f_ack_d;
  logic                x_ack_q, x_ack_d;
  logic [31:0]         f_dtr_q, f_dtr_d;
  logic [31:0]         x_dtr_q, x_dtr_d;
  logic                grant_exec;
  logic                fetch_dropped;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    flush_pend_d = flush_pend_q;
    m_stb_d      = m_stb_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_dout_d     = m_dout_q;
    f_ack_d      = f_ack_q;
    x_ack_d      = x_ack_q;
    f_dtr_d      = f_dtr_q;
    x_dtr_d      = x_dtr_q;
    grant_exec   = 1'b0;
    // A flush seen on the capture edge itself must also drop the response.
    fetch_dropped = flush_pend_q | flush;

    case (state_q)
      ST_IDLE: begin
        if (f_reqm || x_reqm) begin
          grant_exec   = x_reqm && (!f_reqm || !FAIR || (last_grant_q == OWN_FETCH));
          owner_d      = grant_exec ? OWN_EXEC : OWN_FETCH;
          last_grant_d = grant_exec ? OWN_EXEC : OWN_FETCH;
          m_addr_d     = grant_exec ? x_addr : f_addr;
          m_dout_d     = grant_exec ? x_dtw : 32'h0;
          m_we_d       = grant_exec & x_rw;
          m_stb_d      = 1'b1;
          state_d      = ST_BUS;
        end
      end
      ST_BUS: begin
        if (flush && (owner_q == OWN_FETCH)) flush_pend_d = 1'b1;
        if (m_rdy) begin
          m_stb_d = 1'b0;
          m_we_d  = 1'b0;
          state_d = ST_RESP;
          if (owner_q == OWN_EXEC) begin
            x_dtr_d = m_din;
            x_ack_d = 1'b1;
          end else if (!fetch_dropped) begin
            f_dtr_d = m_din;
            f_ack_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        f_ack_d      = 1'b0;
        x_ack_d      = 1'b0;
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_FETCH;
      last_grant_q <= OWN_FETCH;
      flush_pend_q <= 1'b0;
      m_stb_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_dout_q     <= 32'h0;
      f_ack_q      <= 1'b0;
      x_ack_q      <= 1'b0;
      f_dtr_q      <= 32'h0;
      x_dtr_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      flush_pend_q <= flush_pend_d;
      m_stb_q      <= m_stb_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_dout_q     <= m_dout_d;
      f_ack_q      <= f_ack_d;
      x_ack_q      <= x_ack_d;
      f_dtr_q      <= f_dtr_d;
      x_dtr_q      <= x_dtr_d;
    end
  end

  // Flush arriving during the ack cycle still suppresses the fetch ack.
  assign f_ackm = f_ack_q & ~flush;
  assign x_ackm = x_ack_q;
  assign f_dtr  = f_dtr_q;
  assign x_dtr  = x_dtr_q;
  assign m_stb  = m_stb_q;
  assign m_we   = m_we_q;
  assign m_addr = m_addr_q;
  assign m_dout = m_dout_q;

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Directed bench for hs32_mem_arbiter: a FAIR=1 instance (u_dut) and a FAIR=0 instance (u_dut_nf) share stimulus.
module tb_hs32_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] f_addr, x_addr, x_dtw, m_din;
  logic        f_reqm, flush, x_rw, x_reqm, m_rdy;

  logic [31:0] f_dtr, x_dtr, m_addr, m_dout;
  logic        f_ackm, x_ackm, m_we, m_stb;
  logic [31:0] f_dtr1, x_dtr1, m_addr1, m_dout1;
  logic        f_ackm1, x_ackm1, m_we1, m_stb1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hs32_mem_arbiter #(.ADDR_W(32), .FAIR(1'b1)) u_dut (
    .clk(clk), .rstn(rstn), .f_addr(f_addr), .f_reqm(f_reqm), .f_dtr(f_dtr), .f_ackm(f_ackm),
    .flush(flush), .x_addr(x_addr), .x_dtw(x_dtw), .x_rw(x_rw), .x_reqm(x_reqm), .x_dtr(x_dtr),
    .x_ackm(x_ackm), .m_addr(m_addr), .m_dout(m_dout), .m_we(m_we), .m_stb(m_stb),
    .m_din(m_din), .m_rdy(m_rdy)
  );

  hs32_mem_arbiter #(.ADDR_W(32), .FAIR(1'b0)) u_dut_nf (
    .clk(clk), .rstn(rstn), .f_addr(f_addr), .f_reqm(f_reqm), .f_dtr(f_dtr1), .f_ackm(f_ackm1),
    .flush(flush), .x_addr(x_addr), .x_dtw(x_dtw), .x_rw(x_rw), .x_reqm(x_reqm), .x_dtr(x_dtr1),
    .x_ackm(x_ackm1), .m_addr(m_addr1), .m_dout(m_dout1), .m_we(m_we1), .m_stb(m_stb1),
    .m_din(m_din), .m_rdy(m_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        exp_exec;
    logic [31:0] din;
    rstn = 1'b0; f_addr = '0; x_addr = '0; x_dtw = '0; m_din = '0;
    f_reqm = 0; flush = 0; x_rw = 0; x_reqm = 0; m_rdy = 0;
    do_reset();

    // Reset state on both instances
    chk("rst_m_stb", {31'b0, m_stb}, 32'h0);
    chk("rst_m_we", {31'b0, m_we}, 32'h0);
    chk("rst_acks", {30'b0, f_ackm, x_ackm}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_dout", m_dout, 32'h0);
    chk("rst_f_dtr", f_dtr, 32'h0);
    chk("rst_x_dtr", x_dtr, 32'h0);
    chk("rst_nf_stb_ack", {29'b0, m_stb1, f_ackm1, x_ackm1}, 32'h0);

    // Fetch read, zero wait: strobe in cycle 2, ack in cycle 3
    f_reqm = 1; f_addr = 32'h100; m_rdy = 1; m_din = 32'hDEADBEEF;
    step();
    chk("fz_stb", {31'b0, m_stb}, 32'h1);
    chk("fz_addr", m_addr, 32'h100);
    chk("fz_we", {31'b0, m_we}, 32'h0);
    chk("fz_noack", {31'b0, f_ackm}, 32'h0);
    step();
    chk("fz_ack", {31'b0, f_ackm}, 32'h1);
    chk("fz_dtr", f_dtr, 32'hDEADBEEF);
    chk("fz_stb_drop", {31'b0, m_stb}, 32'h0);
    chk("fz_xack", {31'b0, x_ackm}, 32'h0);
    f_reqm = 0;
    step();
    chk("fz_ack_pulse", {31'b0, f_ackm}, 32'h0);

    // Execute write, two wait states
    x_reqm = 1; x_rw = 1; x_addr = 32'h2000; x_dtw = 32'h12345678; m_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("xw_stb%0d", i), {31'b0, m_stb}, 32'h1);
      chk($sformatf("xw_we%0d", i), {31'b0, m_we}, 32'h1);
      chk($sformatf("xw_dout%0d", i), m_dout, 32'h12345678);
      chk($sformatf("xw_addr%0d", i), m_addr, 32'h2000);
      chk($sformatf("xw_noack%0d", i), {31'b0, x_ackm}, 32'h0);
    end
    m_rdy = 1;
    step();
    chk("xw_ack", {31'b0, x_ackm}, 32'h1);
    chk("xw_stb_drop", {31'b0, m_stb}, 32'h0);
    x_reqm = 0; x_rw = 0;
    step();
    chk("xw_ack_pulse", {31'b0, x_ackm}, 32'h0);

    // Execute read with a flush during its bus cycle: flush must not touch it
    x_reqm = 1; x_addr = 32'h3000; m_din = 32'hCAFEF00D;
    step();
    flush = 1;
    step();
    chk("xr_flush_ack", {31'b0, x_ackm}, 32'h1);
    chk("xr_flush_dtr", x_dtr, 32'hCAFEF00D);
    flush = 0; x_reqm = 0;
    step();

    // Stray m_rdy while idle
    m_rdy = 1;
    step();
    step();
    chk("stray_rdy", {29'b0, m_stb, f_ackm, x_ackm}, 32'h0);

    // Contention: FAIR=1 alternates starting with exec, FAIR=0 always exec
    do_reset();
    f_addr = 32'h300; x_addr = 32'h400; f_reqm = 1; x_reqm = 1; m_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      exp_exec = (i % 2 == 0);
      din = 32'hC000_0000 + i;
      m_din = din;
      step();
      chk($sformatf("arb_addr%0d", i), m_addr, exp_exec ? 32'h400 : 32'h300);
      chk($sformatf("arb_nf_addr%0d", i), m_addr1, 32'h400);
      step();
      chk($sformatf("arb_acks%0d", i), {30'b0, x_ackm, f_ackm}, exp_exec ? 32'h2 : 32'h1);
      chk($sformatf("arb_dtr%0d", i), exp_exec ? x_dtr : f_dtr, din);
      chk($sformatf("arb_nf_acks%0d", i), {30'b0, x_ackm1, f_ackm1}, 32'h2);
      chk($sformatf("arb_nf_dtr%0d", i), x_dtr1, din);
      step();
    end
    f_reqm = 0; x_reqm = 0;
    step();

    // Flush in the second bus cycle of a fetch to 0x40
    f_reqm = 1; f_addr = 32'h40; m_rdy = 0; m_din = 32'hBAD0BAD0;
    step();
    chk("fl_stb1", {31'b0, m_stb}, 32'h1);
    step();
    chk("fl_stb2", {31'b0, m_stb}, 32'h1);
    flush = 1; m_rdy = 1;
    step();
    flush = 0; f_reqm = 0;
    chk("fl_stb_done", {31'b0, m_stb}, 32'h0);
    chk("fl_noack", {31'b0, f_ackm}, 32'h0);
    chk("fl_dtr_kept", f_dtr, 32'hC000_0003);
    step();
    chk("fl_noack_idle", {31'b0, f_ackm}, 32'h0);
    f_reqm = 1; f_addr = 32'h80; m_din = 32'h80808080;
    step();
    chk("fl_next_addr", m_addr, 32'h80);
    step();
    chk("fl_next_ack", {31'b0, f_ackm}, 32'h1);
    chk("fl_next_dtr", f_dtr, 32'h80808080);
    f_reqm = 0;
    step();

    // Back-to-back fetches: reassert in the ack cycle, acks at cycles 3/6/9/12
    f_reqm = 1; f_addr = 32'h0; m_din = 32'h1000_0000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("b2b_addr%0d", i), m_addr, 32'(4 * i));
      chk($sformatf("b2b_noack%0d", i), {31'b0, f_ackm}, 32'h0);
      step();
      chk($sformatf("b2b_ack%0d", i), {31'b0, f_ackm}, 32'h1);
      chk($sformatf("b2b_dtr%0d", i), f_dtr, 32'h1000_0000 + i);
      f_addr = 32'(4 * (i + 1));
      m_din = 32'h1000_0000 + i + 1;
      if (i == 3) f_reqm = 0;
      step();
      chk($sformatf("b2b_idle%0d", i), {30'b0, m_stb, f_ackm}, 32'h0);
    end

    // Asynchronous reset while the strobe is up
    f_reqm = 1; f_addr = 32'h500; m_rdy = 0;
    step();
    chk("rb_stb_before", {31'b0, m_stb}, 32'h1);
    #2 rstn = 0;
    #1;
    chk("rb_stb_async", {31'b0, m_stb}, 32'h0);
    chk("rb_acks", {30'b0, f_ackm, x_ackm}, 32'h0);
    chk("rb_addr", m_addr, 32'h0);
    f_reqm = 0;
    step();
    rstn = 1;
    step();
    chk("rb_idle", {30'b0, m_stb, f_ackm}, 32'h0);
    f_reqm = 1; f_addr = 32'h600; m_rdy = 1; m_din = 32'h55AA55AA;
    step();
    chk("rb_next_addr", m_addr, 32'h600);
    step();
    chk("rb_next_ack", {31'b0, f_ackm}, 32'h1);
    chk("rb_next_dtr", f_dtr, 32'h55AA55AA);
    f_reqm = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
